// File: rtl/stack_arbiter_if.sv
// Bundle between two requesters, the arbiter and the shared stack datapath.
// Handshake: a requester raises req with op/wdata stable and holds it until a one-cycle ack; err qualifies ack.
interface stack_arbiter_if #(parameter int DW = 8);
  logic          a_req;
  logic          a_op;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic          a_err;
  logic [DW-1:0] a_rdata;
  logic          b_req;
  logic          b_op;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic          b_err;
  logic [DW-1:0] b_rdata;
  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic          stk_full;
  logic          stk_empty;
  logic          busy;
  logic          gnt_b;
  logic [1:0]    dbg_state;

  modport slave (
    input  a_req, a_op, a_wdata, b_req, b_op, b_wdata, stk_dout, stk_full, stk_empty,
    output a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, stk_push, stk_pop, stk_din,
           busy, gnt_b, dbg_state
  );

  modport master (
    output a_req, a_op, a_wdata, b_req, b_op, b_wdata, stk_dout, stk_full, stk_empty,
    input  a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, stk_push, stk_pop, stk_din,
           busy, gnt_b, dbg_state
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack between requesters A and B.
// Each grant walks IDLE -> ISSUE -> WAIT -> RESP; all outputs registered.
module stack_arbiter #(
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           RstN,
  stack_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t        r_state;
  logic          r_ptr_b;
  logic          r_gnt_b;
  logic          r_op;
  logic          r_err;
  logic          r_push;
  logic          r_pop;
  logic          r_busy;
  logic [DW-1:0] r_din;
  logic          r_a_ack;
  logic          r_a_err;
  logic [DW-1:0] r_a_rdata;
  logic          r_b_ack;
  logic          r_b_err;
  logic [DW-1:0] r_b_rdata;

  logic          w_any;
  logic          w_pick_b;
  logic          w_op;
  logic [DW-1:0] w_wdata;
  logic          w_err;

  // B wins when it is the only requester, or both request and the pointer favours B.
  assign w_any    = arb.a_req | arb.b_req;
  assign w_pick_b = arb.b_req & (~arb.a_req | r_ptr_b);
  assign w_op     = w_pick_b ? arb.b_op : arb.a_op;
  assign w_wdata  = w_pick_b ? arb.b_wdata : arb.a_wdata;
  assign w_err    = w_op ? arb.stk_full : arb.stk_empty;

  always_ff @(posedge clk) begin
    if (!RstN) begin
      r_state   <= IDLE;
      r_ptr_b   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_op      <= 1'b0;
      r_err     <= 1'b0;
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_busy    <= 1'b0;
      r_din     <= '0;
      r_a_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_ack   <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_b <= w_pick_b;
            r_ptr_b <= ~w_pick_b;
            r_op    <= w_op;
            r_err   <= w_err;
            r_din   <= w_wdata;
            r_push  <= w_op & ~w_err;
            r_pop   <= ~w_op & ~w_err;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_push  <= 1'b0;
          r_pop   <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Stack Data_Out is valid here, one cycle after the pop pulse.
          if (r_gnt_b) begin
            r_b_ack <= 1'b1;
            r_b_err <= r_err;
            if (!r_op && !r_err) r_b_rdata <= arb.stk_dout;
          end else begin
            r_a_ack <= 1'b1;
            r_a_err <= r_err;
            if (!r_op && !r_err) r_a_rdata <= arb.stk_dout;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_a_ack <= 1'b0;
          r_a_err <= 1'b0;
          r_b_ack <= 1'b0;
          r_b_err <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arb.a_ack     = r_a_ack;
  assign arb.a_err     = r_a_err;
  assign arb.a_rdata   = r_a_rdata;
  assign arb.b_ack     = r_b_ack;
  assign arb.b_err     = r_b_err;
  assign arb.b_rdata   = r_b_rdata;
  assign arb.stk_push  = r_push;
  assign arb.stk_pop   = r_pop;
  assign arb.stk_din   = r_din;
  assign arb.busy      = r_busy;
  assign arb.gnt_b     = r_gnt_b;
  assign arb.dbg_state = r_state;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: 8-entry stack model behind the DUT, reference stack
// produces {gnt_b, err, rdata} expectations queued per operation.
module tb_stack_arbiter;
  localparam int DW = 8;
  localparam int W  = 10;

  logic clk = 1'b0;
  logic RstN;
  always #5 clk = ~clk;

  stack_arbiter_if #(.DW(DW)) bus ();
  stack_arbiter #(.DW(DW)) dut (.clk(clk), .RstN(RstN), .arb(bus));

  // Physical stack the DUT drives.
  logic [DW-1:0] mem [8];
  logic [3:0]    sp;
  logic          stk_clr;
  logic [DW-1:0] dout_r;

  always @(posedge clk) begin
    if (stk_clr) sp <= 4'd0;
    else if (bus.stk_push && sp != 4'd8) begin
      mem[sp[2:0]] <= bus.stk_din;
      sp <= sp + 4'd1;
    end else if (bus.stk_pop && sp != 4'd0) begin
      dout_r <= mem[3'(sp - 4'd1)];
      sp <= sp - 4'd1;
    end
  end
  assign bus.stk_dout  = dout_r;
  assign bus.stk_full  = (sp == 4'd8);
  assign bus.stk_empty = (sp == 4'd0);

  int push_cnt = 0;
  int pop_cnt  = 0;
  int both_cnt = 0;
  always @(posedge clk) begin
    if (bus.stk_push === 1'b1) push_cnt <= push_cnt + 1;
    if (bus.stk_pop === 1'b1) pop_cnt <= pop_cnt + 1;
    if (bus.stk_push === 1'b1 && bus.stk_pop === 1'b1) both_cnt <= both_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] ref_stk[$];
  logic [DW-1:0] exp_a_rd;
  logic [DW-1:0] exp_b_rd;

  task automatic apply_reset();
    @(negedge clk);
    RstN = 1'b0; stk_clr = 1'b1;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RstN = 1'b1; stk_clr = 1'b0;
    ref_stk.delete(); exp_q.delete();
    exp_a_rd = '0; exp_b_rd = '0;
  endtask

  // Reference result of one operation, in grant order.
  task automatic model_op(input bit side_b, input logic op, input logic [DW-1:0] d);
    logic err;
    logic [DW-1:0] rd;
    err = 1'b0;
    rd  = side_b ? exp_b_rd : exp_a_rd;
    if (op) begin
      if (ref_stk.size() == 8) err = 1'b1;
      else ref_stk.push_back(d);
    end else begin
      if (ref_stk.size() == 0) err = 1'b1;
      else begin
        rd = ref_stk.pop_back();
        if (side_b) exp_b_rd = rd; else exp_a_rd = rd;
      end
    end
    exp_q.push_back({side_b, err, rd});
  endtask

  // One request from one side; returns in the IDLE cycle after RESP.
  task automatic run_op(input bit side_b, input logic op, input logic [DW-1:0] d,
                        output logic [W-1:0] got, output int lat, output int pushes, output int pops);
    int p0, q0;
    p0 = push_cnt; q0 = pop_cnt; lat = 99; got = 'x;
    if (side_b) begin bus.b_req = 1'b1; bus.b_op = op; bus.b_wdata = d; end
    else        begin bus.a_req = 1'b1; bus.a_op = op; bus.a_wdata = d; end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (!side_b && bus.a_ack === 1'b1) begin got = {bus.gnt_b, bus.a_err, bus.a_rdata}; lat = i; break; end
      if (side_b && bus.b_ack === 1'b1) begin got = {bus.gnt_b, bus.b_err, bus.b_rdata}; lat = i; break; end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(posedge clk); @(negedge clk);
    pushes = push_cnt - p0; pops = pop_cnt - q0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    @(negedge clk);
    RstN = 1'b0; stk_clr = 1'b1;
    bus.a_req = 1'b1; bus.b_req = 1'b1; bus.a_op = 1'b1; bus.b_op = 1'b1;
    bus.a_wdata = 8'h05; bus.b_wdata = 8'h06;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      outs = {bus.a_ack, bus.a_err, bus.a_rdata, bus.b_ack, bus.b_err, bus.b_rdata,
              bus.stk_push, bus.stk_pop, bus.stk_din, bus.busy, bus.gnt_b};
      n_tests++;
      if (outs !== 32'd0) begin n_fail++; $display("FAIL reset_outputs[%0d]: got %h expected 00000000", i, outs); end
    end
    RstN = 1'b1; stk_clr = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({bus.gnt_b, bus.busy, bus.dbg_state} !== 4'b0101)
      begin n_fail++; $display("FAIL reset_first_grant: {gnt_b,busy,state} got %b expected 0101", {bus.gnt_b, bus.busy, bus.dbg_state}); end
    apply_reset();
  endtask

  task automatic test_basic();
    logic [W-1:0] got, e;
    int lat, pu, po;
    logic [DW-1:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      model_op(1'b0, 1'b1, vals[i]);
      run_op(1'b0, 1'b1, vals[i], got, lat, pu, po);
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL basic_push_resp[%0d]: got %h expected %h", i, got, e); end
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL basic_push_latency[%0d]: got %0d expected 3", i, lat); end
      n_tests++;
      if (pu !== 1 || po !== 0) begin n_fail++; $display("FAIL basic_push_pulses[%0d]: push %0d pop %0d expected 1 0", i, pu, po); end
    end
    model_op(1'b1, 1'b0, 8'h00);
    run_op(1'b1, 1'b0, 8'h00, got, lat, pu, po);
    e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL basic_pop_resp: got %h expected %h", got, e); end
    n_tests++;
    if (got[7:0] !== 8'h33) begin n_fail++; $display("FAIL basic_pop_data: got %h expected 33", got[7:0]); end
    n_tests++;
    if (pu !== 0 || po !== 1 || lat !== 3) begin n_fail++; $display("FAIL basic_pop_pulses: push %0d pop %0d lat %0d expected 0 1 3", pu, po, lat); end
  endtask

  // Both sides requesting continuously, n operations each.
  task automatic run_dual(input logic op, input int n, input string tag);
    int ai, bi;
    logic [W-1:0] got, e;
    ai = 0; bi = 0;
    bus.a_op = op; bus.b_op = op; bus.a_wdata = 8'hA0; bus.b_wdata = 8'hB0;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int c = 0; c < 100 && (ai < n || bi < n); c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
        got = (bus.a_ack === 1'b1) ? {bus.gnt_b, bus.a_err, bus.a_rdata} : {bus.gnt_b, bus.b_err, bus.b_rdata};
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", tag, ai + bi, got, e); end
        if (bus.a_ack === 1'b1) begin
          ai++;
          if (ai < n) bus.a_wdata = 8'hA0 + 8'(ai); else bus.a_req = 1'b0;
        end else begin
          bi++;
          if (bi < n) bus.b_wdata = 8'hB0 + 8'(bi); else bus.b_req = 1'b0;
        end
      end
    end
    n_tests++;
    if (ai !== n || bi !== n) begin n_fail++; $display("FAIL %s_done: acks a %0d b %0d expected %0d each", tag, ai, bi, n); end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      model_op(1'b0, 1'b1, 8'hA0 + 8'(i));
      model_op(1'b1, 1'b1, 8'hB0 + 8'(i));
    end
    run_dual(1'b1, 4, "fair_push");
    for (int i = 0; i < 4; i++) begin
      model_op(1'b0, 1'b0, 8'h00);
      model_op(1'b1, 1'b0, 8'h00);
    end
    run_dual(1'b0, 4, "fair_pop");
  endtask

  task automatic test_full_empty();
    logic [W-1:0] got, e;
    logic [DW-1:0] d, v0;
    int lat, pu, po;
    apply_reset();
    v0 = '0;
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i == 0) v0 = d;
      model_op(1'b0, 1'b1, d);
      run_op(1'b0, 1'b1, d, got, lat, pu, po);
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL full_push_resp[%0d]: got %h expected %h", i, got, e); end
      n_tests++;
      if (pu !== (i < 8 ? 1 : 0) || lat !== 3) begin n_fail++; $display("FAIL full_push_pulse[%0d]: push %0d lat %0d", i, pu, lat); end
    end
    for (int i = 0; i < 9; i++) begin
      model_op(1'b0, 1'b0, 8'h00);
      run_op(1'b0, 1'b0, 8'h00, got, lat, pu, po);
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL empty_pop_resp[%0d]: got %h expected %h", i, got, e); end
      n_tests++;
      if (po !== (i < 8 ? 1 : 0) || lat !== 3) begin n_fail++; $display("FAIL empty_pop_pulse[%0d]: pop %0d lat %0d", i, po, lat); end
    end
    n_tests++;
    if (got[7:0] !== v0) begin n_fail++; $display("FAIL empty_rdata_hold: got %h expected %h", got[7:0], v0); end
  endtask

  task automatic test_reset_midop();
    bit seen;
    apply_reset();
    bus.a_req = 1'b1; bus.a_op = 1'b1; bus.a_wdata = 8'h5A;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({bus.dbg_state, bus.stk_push} !== 3'b011) begin n_fail++; $display("FAIL midrst_issue: {state,push} got %b expected 011", {bus.dbg_state, bus.stk_push}); end
    RstN = 1'b0; bus.a_req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({bus.dbg_state, bus.stk_push, bus.busy, bus.a_ack} !== 5'b0)
      begin n_fail++; $display("FAIL midrst_idle: {state,push,busy,ack} got %b expected 00000", {bus.dbg_state, bus.stk_push, bus.busy, bus.a_ack}); end
    RstN = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (bus.a_ack !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_ack: got ack %b expected 0", seen); end
  endtask

  task automatic test_req_drop();
    logic [W-1:0] got, e;
    int lat, pu, po, p0, extra;
    apply_reset();
    model_op(1'b0, 1'b1, 8'h77);
    run_op(1'b0, 1'b1, 8'h77, got, lat, pu, po);
    e = exp_q.pop_front();
    n_tests++;
    if (got !== e || lat !== 3) begin n_fail++; $display("FAIL drop_resp: got %h lat %0d expected %h lat 3", got, lat, e); end
    n_tests++;
    if ({bus.busy, bus.dbg_state} !== 3'b000) begin n_fail++; $display("FAIL drop_idle: {busy,state} got %b expected 000", {bus.busy, bus.dbg_state}); end
    p0 = push_cnt; extra = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (bus.busy !== 1'b0) extra++;
    end
    n_tests++;
    if (extra !== 0 || push_cnt !== p0) begin n_fail++; $display("FAIL drop_no_regrant: busy cycles %0d pushes %0d expected 0 0", extra, push_cnt - p0); end
  endtask

  initial begin
    RstN = 1'b0; stk_clr = 1'b1;
    bus.a_req = 1'b0; bus.a_op = 1'b0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_op = 1'b0; bus.b_wdata = '0;
    exp_a_rd = '0; exp_b_rd = '0;
    test_reset();
    test_basic();
    test_fairness();
    test_full_empty();
    test_reset_midop();
    test_req_drop();
    n_tests++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL push_pop_overlap: got %0d cycles expected 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
